pcie_tx_write_arbiter: RTL
==========================

Name: pcie_tx_write_arbiter

Overview:
- Shares the single 128-byte write-request port of the PCIe TX packetizer between N upstream DMA write channels (card-to-host FIFOs).
- Round-robin grant per burst; each burst is 16 x 64-bit words.
- Latches the granted channel's address, muxes its data, and steers the per-word ready pulses back to that channel.
- Sits between the to-PC FIFO channels and the TX packetizer; flags data underruns.

Parameters:
- N, 4, number of write channels (1..8).
- BURST_WORDS, 16, words per write request; fixed by the 128-byte TLP length.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ch_enable  in  N  per-channel enable mask, sampled only at arbitration.
- ch_valid  in  N  channel i holds a full burst and presents word 0 on ch_data.
- ch_address  in  64*N  burst host address; channel i occupies bits [64i+63:64i]; stable while ch_valid[i].
- ch_data  in  64*N  show-ahead data word of channel i.
- ch_data_ready  out  N  pop strobe to channel i (combinational).
- ch_done  out  N  1-cycle pulse when channel i's burst completes.
- write_request_valid  out  1  to the packetizer.
- write_request_address  out  64  to the packetizer, registered.
- write_request_data  out  64  to the packetizer, combinational mux of ch_data[grant].
- write_request_ready  in  1  from the packetizer; pulses once per word, one clock early.
- underrun  out  1  sticky error flag.

Behaviour:
- Reset values: all outputs 0, state IDLE, grant 0, last_grant N-1, word count 0.
- States:
  - IDLE: the search starts at last_grant+1 mod N and picks the first i with ch_valid[i] & ch_enable[i]. The next cycle sets grant=i, latches write_request_address=ch_address[i], sets write_request_valid=1, and goes to BURST. Latency from ch_valid rising to write_request_valid is 1 cycle.
  - BURST: write_request_valid stays 1 until the first ready pulse, then 0 for the rest of the burst. Each cycle write_request_ready=1: ch_data_ready[grant]=1 and word_count++. When the BURST_WORDS-th pulse is seen, go to DONE.
  - DONE (1 cycle): ch_done[grant]=1, last_grant=grant, return to IDLE. write_request_valid is guaranteed low here, so the packetizer cannot relaunch a stale request.
- ch_data_ready is 0 for non-granted channels and in IDLE/DONE. Ready pulses seen in IDLE/DONE are ignored and do not set underrun.
- Underrun is set if write_request_ready=1 in BURST while ch_valid[grant]=0; it clears only on reset. The burst still completes, so the TLP stays 16 words long.
- A channel that drops ch_valid between the IDLE sample and the grant is still granted; this is an upstream contract violation and is not detected.
- ch_enable deasserted mid-burst does not abort the burst; it affects only later arbitration.
- All channels valid: grants rotate 0,1,2,3,0,...; no channel gets two consecutive bursts while another is valid and enabled.
- Reset mid-burst: return to IDLE at once, all outputs 0. The packetizer shares the reset, so no partial TLP remains.
- N=1: the arbiter degenerates to the burst sequencer; last_grant is always 0.

Optional Feature:
- Macro PCIE_TX_WRITE_ARB_STATS_EN.
- When defined: adds output stat_bursts (32*N), one 32-bit wrapping counter per channel. Each counter increments on ch_done[i]; reset to 0; 0xFFFFFFFF wraps to 0.
- When undefined: port and counters are absent; all other behaviour is identical.

Test Plan:
- Single burst: ch_valid[2]=1, address 0x0000_0001_0000_0080, packetizer model pulses ready 16 times. Expect write_request_valid 1 cycle after ch_valid; address latched; 16 ch_data_ready[2] pulses; data words 0..15 in order; ch_done[2] one cycle after the last pulse; underrun=0.
- Round robin: ch_valid=4'b1111 held for 8 bursts -> grant order 0,1,2,3,0,1,2,3; exactly 16 pops per channel per burst; no pops to non-granted channels.
- Enable mask: ch_valid=4'b1111, ch_enable=4'b0101 -> grants alternate 0,2,0,2; channels 1 and 3 see no pops.
- Underrun: ch_valid[1] drops after word 5 of a burst -> underrun=1 from the pulse after the drop, burst still ends after 16 pulses, underrun stays 1 until reset.
- Reset mid-burst: assert reset after 7 ready pulses -> next cycle all outputs 0, state IDLE; with ch_valid[1] still high after reset release, a fresh grant to channel 1 starts from word count 0.
- Stats (macro defined): 3 bursts on channel 0 and 1 on channel 3 -> stat_bursts ch0=3, ch3=1, others 0; counter preloaded to 0xFFFFFFFF wraps to 0 on the next ch_done.

Source files
------------

// File: rtl/pcie_tx_write_arbiter.sv
// pcie_tx_write_arbiter
//   Shares the single 128-byte write-request port of the PCIe TX packetizer
//   between N card-to-host DMA write channels. Grants are round robin, one
//   burst of BURST_WORDS 64-bit words per grant. The granted channel's address
//   is latched, its show-ahead data word is muxed to the packetizer, and the
//   packetizer's per-word ready pulses are steered back as pop strobes.
//
// Ports
//   clock, reset            system clock, synchronous active-high reset
//   ch_enable[N]            per-channel enable, only looked at during arbitration
//   ch_valid[N]             channel holds a full burst, word 0 on ch_data
//   ch_address[64*N]        per-channel burst host address
//   ch_data[64*N]           per-channel show-ahead data word
//   ch_data_ready[N]        combinational pop strobe to the granted channel
//   ch_done[N]              one-cycle pulse when the channel's burst completes
//   write_request_valid     request to packetizer, high until the first ready
//   write_request_address   latched address of the granted burst
//   write_request_data      ch_data of the granted channel (0 outside a burst)
//   write_request_ready     per-word ready pulse from the packetizer
//   underrun                sticky: a word was taken while ch_valid[grant] was low
//
// Optional build macro PCIE_TX_WRITE_ARB_STATS_EN adds stat_bursts[32*N], one
// wrapping completed-burst counter per channel.

module pcie_tx_write_arbiter #(
   parameter int unsigned N           = 4,
   parameter int unsigned BURST_WORDS = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [N-1:0]      ch_enable,
   input  logic [N-1:0]      ch_valid,
   input  logic [64*N-1:0]   ch_address,
   input  logic [64*N-1:0]   ch_data,
   output logic [N-1:0]      ch_data_ready,
   output logic [N-1:0]      ch_done,
   output logic              write_request_valid,
   output logic [63:0]       write_request_address,
   output logic [63:0]       write_request_data,
   input  logic              write_request_ready,
   output logic              underrun
`ifdef PCIE_TX_WRITE_ARB_STATS_EN
   ,
   output logic [32*N-1:0]   stat_bursts
`endif
);

   localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW = $clog2(BURST_WORDS + 1);

   typedef enum logic [1:0] {StIdle, StBurst, StDone} state_e;

   state_e         state_q, state_d;
   logic [GW-1:0]  grant_q, grant_d;
   logic [GW-1:0]  last_grant_q, last_grant_d;
   logic [CW-1:0]  count_q, count_d;
   logic           valid_q, valid_d;
   logic [63:0]    addr_q, addr_d;
   logic           underrun_q, underrun_d;

   logic           found;
   logic [GW-1:0]  pick;
   logic [GW-1:0]  idx;

   // Round-robin search starting one past the previous grant.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = GW'((32'(last_grant_q) + 32'd1 + 32'(k)) % N);
         if (!found && ch_valid[idx] && ch_enable[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_grant_d  = last_grant_q;
      count_d       = count_q;
      valid_d       = valid_q;
      addr_d        = addr_q;
      underrun_d    = underrun_q;
      ch_data_ready = '0;
      ch_done       = '0;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               grant_d = pick;
               addr_d  = ch_address[64*pick +: 64];
               valid_d = 1'b1;
               count_d = '0;
               state_d = StBurst;
            end
         end
         StBurst: begin
            if (write_request_ready) begin
               ch_data_ready[grant_q] = 1'b1;
               valid_d = 1'b0;
               count_d = count_q + CW'(1);
               // The burst runs to full length regardless, keeping the TLP intact.
               if (!ch_valid[grant_q]) underrun_d = 1'b1;
               if (count_q == CW'(BURST_WORDS - 1)) state_d = StDone;
            end
         end
         StDone: begin
            ch_done[grant_q] = 1'b1;
            last_grant_d     = grant_q;
            state_d          = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         last_grant_q <= GW'(N - 1);
         count_q      <= '0;
         valid_q      <= 1'b0;
         addr_q       <= '0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         count_q      <= count_d;
         valid_q      <= valid_d;
         addr_q       <= addr_d;
         underrun_q   <= underrun_d;
      end
   end

   assign write_request_valid   = valid_q;
   assign write_request_address = addr_q;
   assign write_request_data    = (state_q == StBurst) ? ch_data[64*grant_q +: 64] : '0;
   assign underrun              = underrun_q;

`ifdef PCIE_TX_WRITE_ARB_STATS_EN
   logic [32*N-1:0] stat_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         stat_q <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (ch_done[i]) stat_q[32*i +: 32] <= stat_q[32*i +: 32] + 32'd1;
         end
      end
   end

   assign stat_bursts = stat_q;
`endif

endmodule
